uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Each requester submits packets (byte streams terminated by `req_last`). The arbiter grants the transmitter to one requester per packet, forwards bytes one at a time over the transmitter's `tx_valid`/`tx_ready` handshake, and waits for `tx_done` before fetching the next byte. It sits between the system's message sources and the `tx_*` interface of the UART top.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side byte streams, transmitter handshake and arbiter status
// shared between uart_tx_arbiter (slave) and whatever drives it (master).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          burst_cut;
    logic                          gap_timeout;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic                          tx_done;

    modport master (
        output req_valid, req_data, req_last, tx_ready, tx_done,
        input  req_ready, grant, busy, burst_cut, gap_timeout, tx_data, tx_valid
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready, tx_done,
        output req_ready, grant, busy, burst_cut, gap_timeout, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ
// byte-stream requesters, with burst-length and inter-byte gap limits.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int GAP_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]      gidx_q, gidx_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  last_q, last_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  burst_cut_q, burst_cut_d;
    logic                  gap_timeout_q, gap_timeout_d;

    logic                  sel_found;
    logic [PTR_W-1:0]      sel_idx;
    logic                  rel_grant;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(cand);
            end
        end
    end

    assign g_valid = bus.req_valid[gidx_q];
    assign g_last  = bus.req_last[gidx_q];
    assign g_data  = bus.req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        bcnt_d        = bcnt_q;
        gap_d         = gap_q;
        hold_d        = hold_q;
        last_d        = last_q;
        tx_valid_d    = tx_valid_q;
        burst_cut_d   = 1'b0;
        gap_timeout_d = 1'b0;
        rel_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    bcnt_d           = '0;
                    gap_d            = '0;
                    state_d          = FETCH;
                end
            end
            FETCH: begin
                if (g_valid) begin
                    hold_d     = g_data;
                    last_d     = g_last;
                    if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
                    gap_d      = '0;
                    tx_valid_d = 1'b1;
                    state_d    = ISSUE;
                // The IDLE_TIMEOUT-th empty FETCH cycle revokes; the pulse shows one cycle later.
                end else if (IDLE_TIMEOUT != 0) begin
                    if (int'(gap_q) + 1 >= IDLE_TIMEOUT) begin
                        gap_d         = '0;
                        gap_timeout_d = 1'b1;
                        rel_grant     = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        rel_grant = 1'b1;
                    end else if (MAX_BURST != 0 && int'(bcnt_q) == MAX_BURST) begin
                        rel_grant   = 1'b1;
                        burst_cut_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Every release cause hands priority to the requester after the current owner.
        if (rel_grant) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            bcnt_q        <= '0;
            gap_q         <= '0;
            hold_q        <= '0;
            last_q        <= 1'b0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            burst_cut_q   <= 1'b0;
            gap_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            bcnt_q        <= bcnt_d;
            gap_q         <= gap_d;
            hold_q        <= hold_d;
            last_q        <= last_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            burst_cut_q   <= burst_cut_d;
            gap_timeout_q <= gap_timeout_d;
        end
    end

    assign bus.req_ready   = (state_q == FETCH) ? grant_q : '0;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.burst_cut   = burst_cut_q;
    assign bus.gap_timeout = gap_timeout_q;
    assign bus.tx_data     = hold_q;
    assign bus.tx_valid    = tx_valid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a transmitter model
// drive the DUT; a monitor checks every transmitted byte against hand-ordered expectations.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int MAX_BURST    = 16;
    localparam int IDLE_TIMEOUT = 8;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW),
        .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t  exp_q[$];
    byte_t req_q[NUM_REQ][$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_delay = 10;
    int   done_cnt = 0;
    logic tx_ready_en = 1'b1;
    int   burst_cuts = 0;
    int   gap_timeouts = 0;
    int   gap_cycle = 0;
    int   last_hs_cycle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int r, input logic [7:0] base, input int n, input logic with_last);
        byte_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 8'(k);
            b.last = with_last && (k == n - 1);
            req_q[r].push_back(b);
        end
    endtask

    task automatic expect_bytes(input int r, input logic [7:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 2'(r);
            e.data = base + 8'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic int pending_reqs();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += req_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || pending_reqs() != 0 || bus.busy) && c < budget) begin
            step();
            c++;
        end
        check_output(name, 32'(c < budget), 32'd1);
    endtask

    task automatic wait_grant(input logic [NUM_REQ-1:0] mask, input string name);
        int c = 0;
        while (bus.grant !== mask && c < 200) begin
            step();
            c++;
        end
        check_output(name, 32'(bus.grant), 32'(mask));
    endtask

    task automatic wait_tx_valid(input logic level, input string name);
        int c = 0;
        while (bus.tx_valid !== level && c < 200) begin
            step();
            c++;
        end
        check_output(name, 32'(bus.tx_valid), 32'(level));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_grant"},       32'(bus.grant),       32'd0);
        check_output({tag, "_req_ready"},   32'(bus.req_ready),   32'd0);
        check_output({tag, "_tx_valid"},    32'(bus.tx_valid),    32'd0);
        check_output({tag, "_tx_data"},     32'(bus.tx_data),     32'd0);
        check_output({tag, "_busy"},        32'(bus.busy),        32'd0);
        check_output({tag, "_burst_cut"},   32'(bus.burst_cut),   32'd0);
        check_output({tag, "_gap_timeout"}, 32'(bus.gap_timeout), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
        exp_q.delete();
        done_cnt = 0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Requester queues and transmitter model; a byte leaves its queue one cycle after its handshake.
    initial begin
        logic [NUM_REQ-1:0] hs;
        hs            = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
                if (req_q[i].size() > 0) begin
                    bus.req_valid[i]          = 1'b1;
                    bus.req_last[i]           = req_q[i][0].last;
                    bus.req_data[i*DW +: DW]  = req_q[i][0].data;
                end else begin
                    bus.req_valid[i]          = 1'b0;
                    bus.req_last[i]           = 1'b0;
                    bus.req_data[i*DW +: DW]  = '0;
                end
            end
            hs = bus.req_valid & bus.req_ready & {NUM_REQ{!rst}};
            bus.tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.tx_done = 1'b1;
            end
            bus.tx_ready = tx_ready_en;
            if (bus.tx_valid && bus.tx_ready && !rst) done_cnt = done_delay;
        end
    end

    // Monitor: pops the scoreboard on every transmitter handshake and watches release pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.tx_valid && bus.tx_ready) begin
                    last_hs_cycle = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_tx_byte: got 0x%0h from grant 0x%0h, expected none",
                                 bus.tx_data, bus.grant);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("tx_data", 32'(bus.tx_data), 32'(e.data));
                        check_output("tx_grant", 32'(bus.grant), 32'd1 << e.idx);
                    end
                end
                if (bus.burst_cut) begin
                    burst_cuts++;
                    check_output("grant_at_burst_cut", 32'(bus.grant), 32'd0);
                end
                if (bus.gap_timeout) begin
                    gap_timeouts++;
                    gap_cycle = cyc;
                    check_output("grant_at_gap_timeout", 32'(bus.grant), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        $display("[TB] single packet from requester 0");
        done_delay = 10;
        apply_stimulus(0, 8'h41, 3, 1'b1);
        expect_bytes(0, 8'h41, 3);
        step();
        step();
        check_output("lat_grant", 32'(bus.grant), 32'h1);
        check_output("lat_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        check_output("lat_tx_valid", 32'(bus.tx_valid), 32'd1);
        check_output("lat_tx_data", 32'(bus.tx_data), 32'h41);
        wait_drain("t1_drain", 200);
        done_delay = 2;
        apply_stimulus(0, 8'h50, 1, 1'b1);
        apply_stimulus(1, 8'h51, 1, 1'b1);
        expect_bytes(1, 8'h51, 1);
        expect_bytes(0, 8'h50, 1);
        wait_drain("t1_ptr_drain", 200);

        $display("[TB] round-robin order");
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 8'h10 + 8'(i), 1, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) expect_bytes(i, 8'h10 + 8'(i), 1);
        wait_drain("t2_round1", 400);
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 8'h20 + 8'(i), 1, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) expect_bytes(i, 8'h20 + 8'(i), 1);
        wait_drain("t2_round2", 400);

        $display("[TB] forced rotation after MAX_BURST bytes");
        do_reset();
        burst_cuts = 0;
        apply_stimulus(2, 8'h80, 20, 1'b1);
        wait_grant(4'b0100, "t3_first_grant");
        apply_stimulus(1, 8'hA0, 2, 1'b1);
        expect_bytes(2, 8'h80, 16);
        expect_bytes(1, 8'hA0, 2);
        expect_bytes(2, 8'h90, 4);
        wait_drain("t3_drain", 1000);
        check_output("t3_burst_cuts", 32'(burst_cuts), 32'd1);
        apply_stimulus(0, 8'hC0, 16, 1'b1);
        expect_bytes(0, 8'hC0, 16);
        wait_drain("t3_last_at_limit_drain", 1000);
        check_output("t3_no_cut_when_last", 32'(burst_cuts), 32'd1);

        $display("[TB] gap timeout");
        do_reset();
        gap_timeouts = 0;
        apply_stimulus(3, 8'h30, 2, 1'b0);
        expect_bytes(3, 8'h30, 2);
        c = 0;
        while (gap_timeouts == 0 && c < 200) begin
            step();
            c++;
        end
        check_output("t4_gap_timeouts", 32'(gap_timeouts), 32'd1);
        check_output("t4_gap_delay", 32'(gap_cycle - last_hs_cycle), 32'(done_delay + 9));
        apply_stimulus(3, 8'h32, 1, 1'b1);
        apply_stimulus(0, 8'h01, 1, 1'b1);
        expect_bytes(0, 8'h01, 1);
        expect_bytes(3, 8'h32, 1);
        wait_drain("t4_drain", 300);

        $display("[TB] transmitter stall");
        do_reset();
        tx_ready_en = 1'b0;
        apply_stimulus(1, 8'h55, 1, 1'b0);
        apply_stimulus(1, 8'h66, 1, 1'b1);
        expect_bytes(1, 8'h55, 1);
        expect_bytes(1, 8'h66, 1);
        wait_tx_valid(1'b1, "t5_tx_valid_up");
        for (int k = 0; k < 50; k++) begin
            step();
            check_output("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
            check_output("stall_tx_data", 32'(bus.tx_data), 32'h55);
            check_output("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        check_output("stall_no_second_accept", 32'(req_q[1].size()), 32'd1);
        tx_ready_en = 1'b1;
        wait_drain("t5_drain", 300);

        $display("[TB] reset during WAIT_DONE");
        done_delay = 20;
        apply_stimulus(2, 8'h77, 1, 1'b0);
        apply_stimulus(2, 8'h78, 1, 1'b1);
        expect_bytes(2, 8'h77, 1);
        wait_tx_valid(1'b1, "t6_tx_valid_up");
        wait_tx_valid(1'b0, "t6_in_wait_done");
        rst = 1'b1;
        req_q[2].delete();
        step();
        check_all_zero("t6_after_reset");
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            check_output("t6_late_done_busy", 32'(bus.busy), 32'd0);
            check_output("t6_late_done_tx_valid", 32'(bus.tx_valid), 32'd0);
        end
        apply_stimulus(1, 8'h61, 1, 1'b1);
        apply_stimulus(3, 8'h63, 1, 1'b1);
        expect_bytes(1, 8'h61, 1);
        expect_bytes(3, 8'h63, 1);
        wait_drain("t6_ptr_drain", 400);

        check_output("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
